// File: rtl/uart_rx_fsm_if.sv
// Control/status bundle between the UART RX sequencer (master) and its
// sampler/checker/deserializer datapath (slave).
interface uart_rx_fsm_if #(
  parameter int unsigned PRESCALE_W = 6
) ();

  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stop_err;

  logic                  dat_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stop_check_en;
  logic                  data_valid;

  modport master (
    input  rx_in, prescale, par_en, strt_glitch, par_err, stop_err,
    output dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
           par_chk_en, stop_check_en, data_valid
  );

  modport slave (
    output rx_in, prescale, par_en, strt_glitch, par_err, stop_err,
    input  dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
           par_chk_en, stop_check_en, data_valid
  );

endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start detection, oversample/bit counting and
// one-cycle enables for the start/data/parity/stop stages.
module uart_rx_fsm #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fsm_if.master  bus
);

  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] edge_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  samp_q;
  logic                  strt_q;
  logic                  deser_q;
  logic                  par_q;
  logic                  stop_q;
  logic                  valid_q;

  logic [PRESCALE_W-1:0] half_c;
  logic [PRESCALE_W-1:0] pre_samp_c;
  logic [PRESCALE_W-1:0] stop_exit_c;
  logic [PRESCALE_W-1:0] last_edge_c;
  logic [PRESCALE_W-1:0] edge_inc_c;
  logic                  at_pre_samp_c;
  logic                  at_last_c;

  // Enables are registered, so they are armed one edge before the sample point S = P/2+2.
  assign half_c        = p_q >> 1;
  assign pre_samp_c    = half_c + PRESCALE_W'(1);
  assign stop_exit_c   = half_c + PRESCALE_W'(3);
  assign last_edge_c   = p_q - PRESCALE_W'(1);
  assign edge_inc_c    = edge_q + PRESCALE_W'(1);
  assign at_pre_samp_c = (edge_q == pre_samp_c);
  assign at_last_c     = (edge_q == last_edge_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      p_q     <= '0;
      edge_q  <= '0;
      bit_q   <= '0;
      samp_q  <= 1'b0;
      strt_q  <= 1'b0;
      deser_q <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      strt_q  <= 1'b0;
      deser_q <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          edge_q <= '0;
          bit_q  <= '0;
          samp_q <= 1'b0;
          // This cycle is edge 0 of the start bit; the ratio is frozen for the frame.
          if (!bus.rx_in) begin
            state  <= START;
            edge_q <= PRESCALE_W'(1);
            samp_q <= 1'b1;
            p_q    <= bus.prescale;
          end
        end
        START: begin
          edge_q <= edge_inc_c;
          strt_q <= at_pre_samp_c;
          if (at_last_c) begin
            edge_q <= '0;
            if (bus.strt_glitch) begin
              state  <= IDLE;
              samp_q <= 1'b0;
            end else begin
              state <= DATA;
              bit_q <= '0;
            end
          end
        end
        DATA: begin
          edge_q  <= edge_inc_c;
          deser_q <= at_pre_samp_c;
          if (at_last_c) begin
            edge_q <= '0;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              bit_q <= '0;
              state <= bus.par_en ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          edge_q <= edge_inc_c;
          par_q  <= at_pre_samp_c;
          if (at_last_c) begin
            edge_q <= '0;
            if (bus.par_err) begin
              state  <= IDLE;
              samp_q <= 1'b0;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          edge_q <= edge_inc_c;
          stop_q <= at_pre_samp_c;
          // Leave right after the checker result lands so a following start bit is not missed.
          if (edge_q == stop_exit_c) begin
            state   <= IDLE;
            edge_q  <= '0;
            samp_q  <= 1'b0;
            valid_q <= ~bus.stop_err;
          end
        end
        default: begin
          state  <= IDLE;
          samp_q <= 1'b0;
          edge_q <= '0;
          bit_q  <= '0;
        end
      endcase
    end
  end

  assign bus.dat_samp_en   = samp_q;
  assign bus.edge_cnt      = edge_q;
  assign bus.bit_cnt       = bit_q;
  assign bus.strt_chk_en   = strt_q;
  assign bus.deser_en      = deser_q;
  assign bus.par_chk_en    = par_q;
  assign bus.stop_check_en = stop_q;
  assign bus.data_valid    = valid_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a scoreboard of expected enable/valid pulses
// is filled at each frame start and drained by a negedge monitor.
module tb_uart_rx_fsm;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PRESCALE_W = 6;

  localparam int K_STRT  = 0;
  localparam int K_DESER = 1;
  localparam int K_PAR   = 2;
  localparam int K_STOP  = 3;
  localparam int K_VALID = 4;

  localparam int O_OK      = 0;
  localparam int O_GLITCH  = 1;
  localparam int O_PARERR  = 2;
  localparam int O_STOPERR = 3;

  typedef struct {
    int kind;
    int cyc;
    int edg;
    int bitn;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  ev_t  q[$];
  logic inj_glitch, inj_par, inj_stop;
  string kn[5] = '{"strt_chk_en", "deser_en", "par_chk_en", "stop_check_en", "data_valid"};

  uart_rx_fsm_if #(.PRESCALE_W(PRESCALE_W)) bus ();

  uart_rx_fsm #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered checker models with the one-cycle enable-to-error latency.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.strt_glitch <= 1'b0;
      bus.par_err     <= 1'b0;
      bus.stop_err    <= 1'b0;
    end else begin
      if (bus.strt_chk_en)   bus.strt_glitch <= inj_glitch;
      if (bus.par_chk_en)    bus.par_err     <= inj_par;
      if (bus.stop_check_en) bus.stop_err    <= inj_stop;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp_v);
  endtask

  function automatic void push(input int k, input int c, input int e, input int b);
    ev_t ev;
    ev.kind = k; ev.cyc = c; ev.edg = e; ev.bitn = b;
    q.push_back(ev);
  endfunction

  // Expected pulses for one frame starting with edge 0 at cycle t0.
  function automatic void push_frame(input int t0, input int p, input int par, input int outcome);
    int s, ks;
    s = p / 2 + 2;
    push(K_STRT, t0 + s, s, 0);
    if (outcome == O_GLITCH) return;
    for (int k = 1; k <= int'(DATA_W); k++) push(K_DESER, t0 + k * p + s, s, k - 1);
    if (par != 0) begin
      push(K_PAR, t0 + (int'(DATA_W) + 1) * p + s, s, 0);
      if (outcome == O_PARERR) return;
    end
    ks = int'(DATA_W) + 1 + par;
    push(K_STOP, t0 + ks * p + s, s, 0);
    if (outcome == O_OK) push(K_VALID, t0 + ks * p + s + 2, 0, 0);
  endfunction

  function automatic int outs();
    return int'({bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt, bus.strt_chk_en,
                 bus.deser_en, bus.par_chk_en, bus.stop_check_en, bus.data_valid});
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Caller is at a negedge; the line is low for exactly the detecting IDLE cycle.
  task automatic start_frame(input int p, input int par, input int outcome, output int t0);
    bus.rx_in = 1'b0;
    t0 = cyc;
    push_frame(t0, p, par, outcome);
    @(negedge clk);
    bus.rx_in = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [4:0] v;
    ev_t e;
    if (rst) begin
      v = {bus.data_valid, bus.stop_check_en, bus.par_chk_en, bus.deser_en, bus.strt_chk_en};
      if (v != 5'd0) chk("enable_onehot", int'($countones(v[3:0]) <= 1), 1);
      for (int k = 0; k < 5; k++) begin
        if (v[k]) begin
          if (q.size() == 0) begin
            chk($sformatf("unexpected_%s", kn[k]), k, -1);
          end else begin
            e = q.pop_front();
            chk($sformatf("kind(exp %s)", kn[e.kind]), k, e.kind);
            chk($sformatf("%s_cycle", kn[k]), cyc, e.cyc);
            chk($sformatf("%s_edge_cnt", kn[k]), int'(bus.edge_cnt), e.edg);
            chk($sformatf("%s_bit_cnt", kn[k]), int'(bus.bit_cnt), e.bitn);
          end
        end
      end
    end
  end

  initial begin
    int t0, t1;
    rst = 1'b0;
    bus.rx_in = 1'b1;
    bus.prescale = PRESCALE_W'(16);
    bus.par_en = 1'b0;
    inj_glitch = 1'b0; inj_par = 1'b0; inj_stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    @(negedge clk);

    // P=16, no parity, clean frame
    start_frame(16, 0, O_OK, t0);
    wait_cyc(t0 + 155);
    chk("t1_samp_before_exit", int'(bus.dat_samp_en), 1);
    wait_cyc(t0 + 156);
    chk("t1_idle_samp", int'(bus.dat_samp_en), 0);
    chk("t1_idle_edge", int'(bus.edge_cnt), 0);
    wait_cyc(t0 + 175);
    chk("t1_drain", q.size(), 0);

    // P=8, parity enabled, parity error drops the frame
    bus.prescale = PRESCALE_W'(8); bus.par_en = 1'b1; inj_par = 1'b1;
    start_frame(8, 1, O_PARERR, t0);
    wait_cyc(t0 + 79);
    chk("t2_samp_at_decision", int'(bus.dat_samp_en), 1);
    wait_cyc(t0 + 80);
    chk("t2_idle_samp", int'(bus.dat_samp_en), 0);
    chk("t2_idle_edge", int'(bus.edge_cnt), 0);
    wait_cyc(t0 + 110);
    chk("t2_drain", q.size(), 0);
    inj_par = 1'b0; bus.par_en = 1'b0;

    // P=16, start glitch, then a clean start at t0+20
    bus.prescale = PRESCALE_W'(16); inj_glitch = 1'b1;
    start_frame(16, 0, O_GLITCH, t0);
    wait_cyc(t0 + 15);
    chk("t3_samp_at_decision", int'(bus.dat_samp_en), 1);
    wait_cyc(t0 + 16);
    chk("t3_idle_samp", int'(bus.dat_samp_en), 0);
    wait_cyc(t0 + 20);
    inj_glitch = 1'b0;
    start_frame(16, 0, O_OK, t1);
    wait_cyc(t1 + 1);
    chk("t3_restart_samp", int'(bus.dat_samp_en), 1);
    wait_cyc(t1 + 175);
    chk("t3_drain", q.size(), 0);

    // P=32, stop error
    bus.prescale = PRESCALE_W'(32); inj_stop = 1'b1;
    start_frame(32, 0, O_STOPERR, t0);
    wait_cyc(t0 + 307);
    chk("t4_samp_before_exit", int'(bus.dat_samp_en), 1);
    wait_cyc(t0 + 308);
    chk("t4_idle_samp", int'(bus.dat_samp_en), 0);
    wait_cyc(t0 + 330);
    chk("t4_drain", q.size(), 0);
    inj_stop = 1'b0;

    // Back-to-back frames, P=16; a mid-frame prescale change must be ignored
    bus.prescale = PRESCALE_W'(16);
    start_frame(16, 0, O_OK, t0);
    wait_cyc(t0 + 5);
    bus.prescale = PRESCALE_W'(8);
    wait_cyc(t0 + 150);
    bus.prescale = PRESCALE_W'(16);
    wait_cyc(t0 + 156);
    chk("t5_idle_edge", int'(bus.edge_cnt), 0);
    chk("t5_idle_bit", int'(bus.bit_cnt), 0);
    wait_cyc(t0 + 160);
    start_frame(16, 0, O_OK, t1);
    wait_cyc(t1 + 1);
    chk("t5_restart_edge", int'(bus.edge_cnt), 1);
    chk("t5_restart_bit", int'(bus.bit_cnt), 0);
    wait_cyc(t1 + 175);
    chk("t5_drain", q.size(), 0);

    // Reset in the middle of a frame, then a full frame
    start_frame(16, 0, O_OK, t0);
    wait_cyc(t0 + 40);
    #2 rst = 1'b0;
    #1 chk("t6_async_reset_outputs", outs(), 0);
    while (q.size() > 0 && q[$].cyc >= t0 + 40) void'(q.pop_back());
    chk("t6_reset_drain", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("t6_held_reset_outputs", outs(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_idle_after_release", outs(), 0);
    start_frame(16, 0, O_OK, t1);
    wait_cyc(t1 + 175);
    chk("t6_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
